register_file: RTL and testbench

Integer register file for the RV32I core: 32 general-purpose registers, 32 bits each. It provides two combinational read ports (rs1, rs2) and one synchronous write port (rd). Register x0 is hardwired to zero. It sits in the decode/writeback path between instruction decode and ALU operand selection.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/register_file.sv | 50 +++++
 tb/tb_register_file.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types for the integer register file.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file.sv
// RV32I integer register file: 2 combinational read ports, 1 synchronous write port, x0 = 0.
// Optional same-cycle write forwarding enabled by defining REGFILE_WRITE_BYPASS_EN.
module register_file
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]       rd_data,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data
);

  xlen_t regs [NUM_REGS];

  // Entry 0 is never written after reset; reads of x0 are forced to zero below.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (we && (rd != REG_ZERO)) begin
      regs[rd] <= rd_data;
    end
  end

  // Shared read-port mux: zero check, stored value, optional forwarding of the pending write.
  function automatic xlen_t read_port(input reg_addr_t addr);
    xlen_t val;
    val = regs[addr];
    if (addr == REG_ZERO) begin
      val = '0;
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    else if (!rst && we && (rd != REG_ZERO) && (addr == rd)) begin
      val = rd_data;
    end
`endif
    return val;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1);
    rs2_data = read_port(rs2);
  end

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array-based reference model.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int n_checks;
  int n_fails;

  logic [31:0] mdl [32];
  bit          mdl_valid;
  bit          done;

  register_file dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .rd_data  (rd_data),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // What a read port must show right now, from the architectural rules.
  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!rst && we && rd != 5'd0 && addr == rd) return rd_data;
`endif
    return mdl[addr];
  endfunction

  // Reference state: updated once per rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      mdl_valid = 1'b1;
    end else if (we && rd != 5'd0) begin
      mdl[rd] = rd_data;
    end
  end

  // Compare process: every cycle once the model state is defined.
  always @(negedge clk) begin
    if (!done) begin
      if (mdl_valid || rs1 == 5'd0) check("rs1_model", rs1_data, exp_read(rs1));
      if (mdl_valid || rs2 == 5'd0) check("rs2_model", rs2_data, exp_read(rs2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; rd = a; rd_data = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fails = 0; mdl_valid = 1'b0; done = 1'b0;
    rst = 1'b0; we = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; rd_data = 32'h0;
    #2;
    check("x0_before_reset", rs1_data, 32'h0);

    // Reset with a write pending: the write must be dropped.
    rst = 1'b1; we = 1'b1; rd = 5'd9; rd_data = 32'h000000FF;
    step();
    rst = 1'b0; we = 1'b0; rs1 = 5'd5; rs2 = 5'd31;
    #1;
    check("reset_rs1_x5", rs1_data, 32'h0);
    check("reset_rs2_x31", rs2_data, 32'h0);
    rs1 = 5'd9; #1;
    check("reset_write_dropped", rs1_data, 32'h0);

    wr(5'd1, 32'hDEADBEEF);
    rs1 = 5'd1; rs2 = 5'd2; #1;
    check("basic_x1", rs1_data, 32'hDEADBEEF);
    check("basic_x2", rs2_data, 32'h0);

    wr(5'd0, 32'h12345678);
    rs1 = 5'd0; rs2 = 5'd0; #1;
    check("x0_rs1", rs1_data, 32'h0);
    check("x0_rs2", rs2_data, 32'h0);

    wr(5'd3, 32'hAAAA5555);
    we = 1'b0; rd = 5'd3; rd_data = 32'hFFFFFFFF;
    step();
    rs1 = 5'd3; #1;
    check("we_gating_x3", rs1_data, 32'hAAAA5555);

    wr(5'd31, 32'h0000000F);
    wr(5'd31, 32'hF0F0F0F0);
    wr(5'd7, 32'h00000007);
    rs1 = 5'd31; rs2 = 5'd7; #1;
    check("dual_x31", rs1_data, 32'hF0F0F0F0);
    check("dual_x7", rs2_data, 32'h00000007);
    rs2 = 5'd31; #1;
    check("same_addr_rs1", rs1_data, 32'hF0F0F0F0);
    check("same_addr_rs2", rs2_data, 32'hF0F0F0F0);

    wr(5'd4, 32'h11111111);
    rs1 = 5'd4; we = 1'b1; rd = 5'd4; rd_data = 32'h22222222; #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rw_before_edge", rs1_data, 32'h22222222);
`else
    check("rw_before_edge", rs1_data, 32'h11111111);
`endif
    step();
    we = 1'b0; #1;
    check("rw_after_edge", rs1_data, 32'h22222222);

    // Mid-run reset with a write to x4 pending: no forwarding, then cleared.
    rst = 1'b1; we = 1'b1; rd = 5'd4; rd_data = 32'h33333333; #1;
    check("rst_no_bypass", rs1_data, 32'h22222222);
    step();
    rst = 1'b0; we = 1'b0; #1;
    check("midrun_reset_x4", rs1_data, 32'h0);

    // Random phase; rd is steered onto a read address often to exercise same-cycle hazards.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(63) == 0);
      we      = $urandom_range(1);
      rs1     = 5'($urandom_range(31));
      rs2     = ($urandom_range(3) == 0) ? rs1 : 5'($urandom_range(31));
      case ($urandom_range(3))
        0:       rd = rs1;
        1:       rd = rs2;
        2:       rd = 5'd0;
        default: rd = 5'($urandom_range(31));
      endcase
      rd_data = $urandom();
      step();
    end

    rst = 1'b0; we = 1'b0;
    @(posedge clk);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
